// File: rtl/qadd_rr_arb_pkg.sv
// Shared fixed-point format constants and helpers for the arbitrated adder.
// Saturation helpers are only used when QADD_ARB_SAT_EN is defined.
package qadd_rr_arb_pkg;
  localparam int QADD_N = 32;
  localparam int QADD_Q = 15;

  // The saturation limits are returned in 64 bits; callers keep the low N bits.
  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction
endpackage

// File: rtl/qadd.sv
// Fixed-point two's-complement adder with signed-overflow flag.
// Q only documents the binary-point position; the add itself does not use it.
module qadd
  import qadd_rr_arb_pkg::*;
#(
  parameter int N = QADD_N,
  parameter int Q = QADD_Q
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] c_o,
  output logic         ovf_o
);
  assign c_o   = a_i + b_i;
  assign ovf_o = add_ovf(a_i[N-1], b_i[N-1], c_o[N-1]);
endmodule

// File: rtl/qadd_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module qadd_rr_arb_rr_pick #(
  parameter int R = 4
) (
  input  logic [R-1:0]         req_i,
  input  logic [$clog2(R)-1:0] ptr_i,
  output logic [R-1:0]         gnt_o,
  output logic [$clog2(R)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(R);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < R; k++) begin
      j = (int'(ptr_i) + k) % R;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/qadd_rr_arb.sv
// One shared fixed-point adder behind a round-robin arbiter with a single result slot.
// Define QADD_ARB_SAT_EN to saturate the result on signed overflow.
module qadd_rr_arb
  import qadd_rr_arb_pkg::*;
#(
  parameter int N = QADD_N,
  parameter int Q = QADD_Q,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req_valid,
  output logic [R-1:0]         req_ready,
  input  logic [R*N-1:0]       req_a,
  input  logic [R*N-1:0]       req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_c,
  output logic [$clog2(R)-1:0] rsp_id,
  output logic                 rsp_ovf
);
  localparam int IW = $clog2(R);

  logic [R-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          can_accept, grant;
  logic [N-1:0]  a_sel, b_sel, sum;
  logic          sum_ovf;

  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_c_q, rsp_c_d;
  logic [IW-1:0] rsp_id_q;
  logic          rsp_ovf_q;
  logic [IW-1:0] ptr_q, ptr_d;

  qadd_rr_arb_rr_pick #(.R(R)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign grant      = can_accept && pick_any;
  // Held low during reset so requesters never see an accept that is not taken.
  assign req_ready  = (grant && !rst) ? pick_gnt : '0;

  assign a_sel = req_a[int'(pick_idx)*N +: N];
  assign b_sel = req_b[int'(pick_idx)*N +: N];

  qadd #(.N(N), .Q(Q)) u_add (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .c_o   (sum),
    .ovf_o (sum_ovf)
  );

`ifdef QADD_ARB_SAT_EN
  localparam logic [63:0] SMAX = sat_max(N);
  localparam logic [63:0] SMIN = sat_min(N);
  // Overflow only happens with equal operand signs, so a's sign picks the rail.
  assign rsp_c_d = !sum_ovf ? sum : (a_sel[N-1] ? SMIN[N-1:0] : SMAX[N-1:0]);
`else
  assign rsp_c_d = sum;
`endif

  assign ptr_d       = (pick_idx == IW'(R - 1)) ? '0 : pick_idx + 1'b1;
  assign rsp_valid_d = grant || (rsp_valid_q && !rsp_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (grant) begin
        rsp_c_q   <= rsp_c_d;
        rsp_id_q  <= pick_idx;
        rsp_ovf_q <= sum_ovf;
        ptr_q     <= ptr_d;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;
endmodule

// File: doc/qadd_rr_arb.md
Name: qadd_rr_arb

Overview:
- Shares one fixed-point two's-complement adder between R requesters.
- Round-robin arbitration on the request side; one registered result slot on the response side, tagged with the requester index.
- Sits between compute lanes (e.g. MAC/accumulate engines) and a single adder instance, so an area-constrained datapath needs only one adder.

Parameters:
- N, 32, total word width (sign + integer + fraction bits)
- Q, 15, fractional bits; passed to the adder and used only for documentation/format, not by the add itself
- R, 4, number of requesters; legal range 2..16
- IW, $clog2(R), requester-index width (derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  R  per-requester operand valid
- req_ready  out  R  per-requester accept; one-hot or zero
- req_a  in  R*N  operand A per requester; requester i occupies bits [i*N +: N]
- req_b  in  R*N  operand B per requester, same packing as req_a
- rsp_valid  out  1  result slot holds a valid result
- rsp_ready  in  1  downstream accepts the result
- rsp_c  out  N  sum a+b
- rsp_id  out  IW  index of the requester that produced rsp_c
- rsp_ovf  out  1  signed overflow: operands share a sign and the raw sum sign differs

Behaviour:
- Reset values (asynchronous, held while rst=1):
  - rsp_valid=0, rsp_c=0, rsp_id=0, rsp_ovf=0, round-robin pointer ptr=0
  - req_ready=0
- Slot states, encoded by rsp_valid:
  - EMPTY to FULL on a grant.
  - FULL to EMPTY on rsp_ready with no new grant.
  - FULL to FULL on rsp_ready plus a grant in the same cycle (back-to-back).
  - FULL with rsp_ready=0 holds rsp_c, rsp_id and rsp_ovf stable.
- Grant condition: can_accept = !rsp_valid || rsp_ready. No grant when can_accept=0.
- Arbitration when can_accept=1:
  - Search req_valid starting at index ptr, ascending, wrapping R-1 to 0.
  - First set bit g is granted; req_ready[g]=1, all other bits 0.
- req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready. Requesters must not derive req_valid from req_ready.
- On a grant at edge t:
  - rsp_c <= req_a[g] + req_b[g], truncated to N bits
  - rsp_id <= g; rsp_ovf computed from that add; rsp_valid <= 1
  - ptr <= (g+1) mod R
- Without a grant, ptr is unchanged.
- Latency: 1 cycle from accept to rsp_valid. Throughput: 1 result/cycle while rsp_ready=1.
- Fairness: a requester that keeps req_valid high is granted within R grants.
- Requesters keep req_a, req_b and req_valid stable until accepted; the block does not sample operands before grant.
- Single requester active: granted every cycle the slot can accept.
- Reset mid-transfer: any in-flight result is dropped and ptr returns to 0; requesters re-present their operands.

Optional Feature:
- Macro QADD_ARB_SAT_EN.
- Defined: on overflow, rsp_c saturates to the most positive value (0 followed by N-1 ones) or the most negative (1 followed by N-1 zeros), selected by operand sign; rsp_ovf is still reported.
- Undefined: rsp_c is the wrapped two's-complement sum; rsp_ovf is reported identically.

Decomposition:
- Shared package holds:
  - the fixed-point format constants: default N and Q
  - the saturation max/min constant functions of N
  - the overflow-detect function
- Adder: reuse the existing fixed-point adder module for the sum.
- Natural sub-module: rr_pick. Combinational round-robin picker with inputs (req vector, ptr) and outputs (one-hot grant, binary index, any_grant). Parameterised by R.

Test Plan:
- Reset, then one request: req_valid=0001, a=0x00010000, b=0x00008000 (N=32, Q=15) -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_c=0x00018000, rsp_id=0.
- All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,… one per cycle; rsp_id sequence matches.
- Backpressure: slot FULL, rsp_ready=0 for 3 cycles with req_valid=0110 -> req_ready=0 throughout; rsp_c/rsp_id stable. Raise rsp_ready -> requester 1 granted in that cycle, then requester 2.
- Overflow: a=0x7FFFFFFF, b=0x00000001 -> rsp_ovf=1; rsp_c=0x80000000 without QADD_ARB_SAT_EN, 0x7FFFFFFF with it. Also a=0x80000000, b=0xFFFFFFFF -> rsp_ovf=1; rsp_c=0x7FFFFFFF without the macro, 0x80000000 with it.
- Negative add without overflow: a=0xFFFF8000 (-1.0), b=0x00004000 (+0.5) -> rsp_c=0xFFFFC000, rsp_ovf=0.
- Assert rst while rsp_valid=1 and ptr=2 -> rsp_valid=0 and req_ready=0 immediately; after release, req_valid=1111 -> requester 0 granted first.
